// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU byte-memory port: widths, command op
// encodings and the memory-port master state type.
package cpu_mem_pkg;

  localparam int CPU_ADDR_W = 13;
  localparam int CPU_DATA_W = 8;

  localparam logic [1:0] OP_READ1  = 2'b00;
  localparam logic [1:0] OP_READ2  = 2'b01;
  localparam logic [1:0] OP_WRITE1 = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_HI,
    ST_RD_LO,
    ST_WR,
    ST_RESP
  } mem_state_t;

endpackage

// File: rtl/mem_port_master.sv
// CPU-side initiator for the byte-wide instruction/data memory. Runs one
// command at a time (single read, big-endian pair read, single write) and
// reports completion with a one-cycle response pulse.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | ready for a command; accept loads mem_addr/mem_wdata
// ST_RD_HI | hold mem_addr for WAIT_CYCLES, sample first (high) byte
// ST_RD_LO | hold mem_addr+1 for WAIT_CYCLES, sample low byte (READ2)
// ST_WR    | mem_we high for this single cycle
// ST_RESP  | rsp_valid pulse; reserved ops land here directly with error
module mem_port_master
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W      = CPU_ADDR_W,
  parameter int DATA_W      = CPU_DATA_W,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  output logic                rsp_valid,
  output logic [2*DATA_W-1:0] rsp_data,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_we,
  input  logic [DATA_W-1:0]   mem_rdata
);

  // The wait counter loads this value and counts down; zero marks the
  // sampling cycle of a read state.
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  mem_state_t          state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [3:0]          wait_q, wait_d;
  logic [2*DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;

  // State and datapath registers; async reset aborts any command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_READ1;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hi_q        <= '0;
      wait_q      <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hi_q        <= hi_d;
      wait_q      <= wait_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state, datapath updates and state-decoded strobes.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hi_d        = hi_q;
    wait_d      = wait_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    cmd_ready   = 1'b0;
    mem_we      = 1'b0;
    rsp_valid   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d        = cmd_op;
          mem_addr_d  = cmd_addr;
          mem_wdata_d = cmd_wdata;
          wait_d      = WAIT_INIT;
          case (cmd_op)
            OP_READ1, OP_READ2: state_d = ST_RD_HI;
            OP_WRITE1:          state_d = ST_WR;
            default: begin
              state_d    = ST_RESP;
              rsp_data_d = '0;
              rsp_err_d  = 1'b1;
            end
          endcase
        end
      end

      ST_RD_HI: begin
        if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end else if (op_q == OP_READ2) begin
          hi_d       = mem_rdata;
          mem_addr_d = mem_addr_q + ADDR_ONE;
          wait_d     = WAIT_INIT;
          state_d    = ST_RD_LO;
        end else begin
          rsp_data_d = {{DATA_W{1'b0}}, mem_rdata};
          rsp_err_d  = 1'b0;
          state_d    = ST_RESP;
        end
      end

      ST_RD_LO: begin
        if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end else begin
          rsp_data_d = {hi_q, mem_rdata};
          rsp_err_d  = 1'b0;
          state_d    = ST_RESP;
        end
      end

      ST_WR: begin
        mem_we     = 1'b1;
        rsp_data_d = '0;
        rsp_err_d  = 1'b0;
        state_d    = ST_RESP;
      end

      ST_RESP: begin
        rsp_valid = 1'b1;
        state_d   = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_port_master.sv
// Directed bench for mem_port_master: one instance with no read wait states
// and one with two, each attached to its own behavioural byte memory.
module tb_mem_port_master;
  import cpu_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cv0, cv2;
  logic [1:0]  cmd_op;
  logic [12:0] cmd_addr;
  logic [7:0]  cmd_wdata;

  logic        ready0, rv0, re0, we0;
  logic [15:0] rd0;
  logic [12:0] ma0;
  logic [7:0]  mw0, mr0;
  logic        ready2, rv2, re2, we2;
  logic [15:0] rd2;
  logic [12:0] ma2;
  logic [7:0]  mw2, mr2;

  logic [7:0]  mem0 [0:8191];
  logic [7:0]  mem2 [0:8191];
  logic        pl_en;
  int          pl_sel;
  logic [12:0] pl_addr;
  logic [7:0]  pl_data;
  logic        ovr_en;
  logic [7:0]  ovr_val;
  logic [63:0] ovr_mask;

  int          vectors = 0;
  int          miscompares = 0;
  int          we_cnt;
  logic [12:0] we_addr;
  logic [12:0] trace [0:63];

  always #5 clk = ~clk;

  mem_port_master #(.ADDR_W(13), .DATA_W(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cv0), .cmd_ready(ready0), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rv0), .rsp_data(rd0),
    .rsp_err(re0), .mem_addr(ma0), .mem_wdata(mw0), .mem_we(we0), .mem_rdata(mr0));

  mem_port_master #(.ADDR_W(13), .DATA_W(8), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .cmd_valid(cv2), .cmd_ready(ready2), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rv2), .rsp_data(rd2),
    .rsp_err(re2), .mem_addr(ma2), .mem_wdata(mw2), .mem_we(we2), .mem_rdata(mr2));

  assign mr0 = mem0[ma0];
  assign mr2 = ovr_en ? ovr_val : mem2[ma2];

  always @(posedge clk) begin
    if (pl_en && pl_sel == 0) mem0[pl_addr] <= pl_data;
    else if (we0)             mem0[ma0]     <= mw0;
    if (pl_en && pl_sel == 2) mem2[pl_addr] <= pl_data;
    else if (we2)             mem2[ma2]     <= mw2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int which, input logic [12:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_sel = which; pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issue one command, find the response cycle (relative to the accept edge)
  // within a bounded window and record mem_addr / mem_we per cycle.
  task automatic do_cmd(input int which, input logic [1:0] op, input logic [12:0] addr,
                        input logic [7:0] wd, input int exp_lat, input logic [15:0] exp_data,
                        input logic exp_err, input string tag);
    int          lat;
    logic [15:0] got_data;
    logic        got_err;
    lat = 0; got_data = '0; got_err = 1'b0; we_cnt = 0;
    @(negedge clk);
    chk({tag, "/ready"}, (which == 2) ? ready2 : ready0, 32'd1);
    cmd_op = op; cmd_addr = addr; cmd_wdata = wd; ovr_en = 1'b0;
    if (which == 2) cv2 = 1'b1; else cv0 = 1'b1;
    for (int k = 1; k < 60 && lat == 0; k++) begin
      @(negedge clk);
      cv0 = 1'b0; cv2 = 1'b0;
      cmd_op = 2'($urandom); cmd_addr = 13'($urandom); cmd_wdata = 8'($urandom);
      ovr_en = ovr_mask[k];
      trace[k] = (which == 2) ? ma2 : ma0;
      if ((which == 2) ? we2 : we0) begin
        we_cnt++;
        we_addr = (which == 2) ? ma2 : ma0;
      end
      if ((which == 2) ? rv2 : rv0) begin
        lat      = k;
        got_data = (which == 2) ? rd2 : rd0;
        got_err  = (which == 2) ? re2 : re0;
      end
    end
    ovr_en = 1'b0;
    chk({tag, "/latency"}, lat, exp_lat);
    if (lat != 0) begin
      if (!exp_err) chk({tag, "/data"}, got_data, exp_data);
      chk({tag, "/err"}, got_err, exp_err);
    end
    @(negedge clk);
    chk({tag, "/pulse_end"}, (which == 2) ? rv2 : rv0, 32'd0);
    chk({tag, "/data_hold"}, (which == 2) ? rd2 : rd0, got_data);
    chk({tag, "/ready_after"}, (which == 2) ? ready2 : ready0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hits;
    rst = 1'b1; cv0 = 1'b0; cv2 = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0;
    pl_en = 1'b0; pl_sel = 0; pl_addr = '0; pl_data = '0;
    ovr_en = 1'b0; ovr_val = 8'h55; ovr_mask = '0; we_addr = '0;

    @(negedge clk);
    chk("reset/mem_addr",  ma0, 32'd0);
    chk("reset/mem_wdata", mw0, 32'd0);
    chk("reset/mem_we",    we0, 32'd0);
    chk("reset/rsp_valid", rv0, 32'd0);
    chk("reset/rsp_data",  rd0, 32'd0);
    chk("reset/rsp_err",   re0, 32'd0);

    preload(0, 13'd1000, 8'h1A);
    preload(0, 13'd1, 8'h43);
    preload(0, 13'd2, 8'hE8);
    preload(0, 13'h1FFF, 8'hAB);
    preload(0, 13'd0, 8'hE0);
    preload(0, 13'd3000, 8'h77);
    preload(2, 13'd1, 8'h43);
    preload(2, 13'd2, 8'hE8);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset/ready0", ready0, 32'd1);
    chk("reset/ready2", ready2, 32'd1);

    do_cmd(0, OP_READ1, 13'd1000, 8'h00, 2, 16'h001A, 1'b0, "read1");

    do_cmd(0, OP_READ2, 13'd1, 8'h00, 3, 16'h43E8, 1'b0, "read2");
    chk("read2/addr_hi", trace[1], 32'd1);
    chk("read2/addr_lo", trace[2], 32'd2);

    do_cmd(0, OP_READ2, 13'h1FFF, 8'h00, 3, 16'hABE0, 1'b0, "read2_wrap");
    chk("read2_wrap/addr_hi", trace[1], 32'h1FFF);
    chk("read2_wrap/addr_lo", trace[2], 32'h0000);

    do_cmd(0, OP_WRITE1, 13'd2001, 8'hD0, 2, 16'h0000, 1'b0, "write1");
    chk("write1/we_cycles", we_cnt, 32'd1);
    chk("write1/we_addr", we_addr, 32'd2001);
    do_cmd(0, OP_READ1, 13'd2001, 8'h00, 2, 16'h00D0, 1'b0, "write_read");

    do_cmd(0, OP_RSVD, 13'd5, 8'h00, 1, 16'h0000, 1'b1, "rsvd");
    chk("rsvd/we_cycles", we_cnt, 32'd0);
    do_cmd(0, OP_READ1, 13'd1000, 8'h00, 2, 16'h001A, 1'b0, "after_rsvd");

    // Wait-state instance: foreign bytes on every hold cycle except the last.
    ovr_mask = 64'h36;
    do_cmd(2, OP_READ2, 13'd1, 8'h00, 7, 16'h43E8, 1'b0, "wait_read2");
    chk("wait_read2/addr_hi", trace[3], 32'd1);
    chk("wait_read2/addr_lo", trace[4], 32'd2);
    ovr_mask = 64'h06;
    do_cmd(2, OP_READ1, 13'd2, 8'h00, 4, 16'h00E8, 1'b0, "wait_read1");
    ovr_mask = '0;

    // Reset during the low-byte phase of a pair read.
    @(negedge clk);
    cmd_op = OP_READ2; cmd_addr = 13'd1; cv0 = 1'b1;
    @(negedge clk);
    cv0 = 1'b0;
    @(negedge clk);
    chk("abort_rd/addr_lo", ma0, 32'd2);
    rst = 1'b1;
    #1;
    chk("abort_rd/rsp_valid", rv0, 32'd0);
    chk("abort_rd/mem_we", we0, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rv0) hits++;
    end
    chk("abort_rd/no_rsp", hits, 32'd0);
    chk("abort_rd/ready", ready0, 32'd1);
    do_cmd(0, OP_READ1, 13'd1000, 8'h00, 2, 16'h001A, 1'b0, "abort_rd_next");

    // Reset while the write strobe is up: the write must not land.
    @(negedge clk);
    cmd_op = OP_WRITE1; cmd_addr = 13'd3000; cmd_wdata = 8'h99; cv0 = 1'b1;
    @(negedge clk);
    cv0 = 1'b0;
    chk("abort_wr/we_before", we0, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_wr/we_dropped", we0, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rv0) hits++;
    end
    chk("abort_wr/no_rsp", hits, 32'd0);
    chk("abort_wr/ready", ready0, 32'd1);
    do_cmd(0, OP_READ1, 13'd3000, 8'h00, 2, 16'h0077, 1'b0, "abort_wr_next");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
